// File: rtl/datamem_responder.sv
// Multi-cycle byte-serial data memory responder: one request in flight, one byte per cycle, big-endian.
// Optional power-on memory clear sweep enabled by defining DATAMEM_ZERO_INIT_EN.
module datamem_responder #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_enable,
  input  logic              read_enable,
  input  logic [63:0]       write_data,
  input  logic [3:0]        xfer_size,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       read_data,
  output logic              resp_error
);
  localparam int AW = $clog2(DEPTH);

`ifdef DATAMEM_ZERO_INIT_EN
  localparam int CW = AW - 3;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLEAR} state_t;
  localparam state_t RESET_ST = CLEAR;
  logic [CW-1:0] clr_q;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam state_t RESET_ST = IDLE;
`endif

  state_t state_q, state_d;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   addr_q;
  logic [3:0]      size_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic            re_q;
  logic            err_q;
  logic [63:0]     wd_q;
  logic [63:0]     shift_q;
  logic [AW-1:0]   idx;
  logic            last;
  logic            accept;
  logic            size_ok;
  logic            align_ok;
  logic            range_ok;
  logic            req_err;
  logic [ADDR_W:0] end_addr;

  // Request legality, evaluated on the request being accepted
  always_comb begin
    size_ok  = xfer_size inside {4'd1, 4'd2, 4'd4, 4'd8};
    align_ok = (address[2:0] & (xfer_size[2:0] - 3'd1)) == 3'd0;
    end_addr = {1'b0, address} + (ADDR_W+1)'(xfer_size);
    range_ok = end_addr <= (ADDR_W+1)'(DEPTH);
    req_err  = !(size_ok && align_ok && range_ok);
    accept   = req_valid && req_ready;
    idx      = addr_q + AW'(cnt_q);
    last     = cnt_q == (size_q - 4'd1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err || !(write_enable || read_enable)) state_d = RESP;
          else                                           state_d = ACCESS;
        end
      end
      ACCESS: if (last) state_d = RESP;
      RESP:   if (resp_ready) state_d = IDLE;
`ifdef DATAMEM_ZERO_INIT_EN
      CLEAR:  if (&clr_q) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_error = resp_valid && err_q;
  assign read_data  = (resp_valid && re_q && !err_q) ? shift_q : 64'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_ST;
`ifdef DATAMEM_ZERO_INIT_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef DATAMEM_ZERO_INIT_EN
      if (state_q == CLEAR) clr_q <= clr_q + 1'b1;
`endif
    end
  end

  // Store data is pre-aligned so the next byte to write is always in bits [63:56]
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= address[AW-1:0];
      size_q  <= xfer_size;
      we_q    <= write_enable;
      re_q    <= read_enable;
      err_q   <= req_err;
      wd_q    <= write_data << {4'd8 - xfer_size, 3'b000};
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (state_q == ACCESS) begin
      shift_q <= {shift_q[55:0], mem[idx]};
      wd_q    <= wd_q << 8;
      cnt_q   <= cnt_q + 4'd1;
    end
  end

  // A reset in the same cycle suppresses the write so aborted stores stop cleanly
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ACCESS && we_q) mem[idx] <= wd_q[63:56];
`ifdef DATAMEM_ZERO_INIT_EN
      if (state_q == CLEAR) begin
        for (int j = 0; j < 8; j++) mem[{clr_q, j[2:0]}] <= 8'h00;
      end
`endif
    end
  end

endmodule
